// File: rtl/clock_time_ctrl.sv
// Digit sequencing controller for a 24-hour BCD clock built from raw 4-bit counters.
// Decides per-digit enable/clear strobes and runs the RUN / SET_HR / SET_MIN mode FSM.
module clock_time_ctrl #(
    parameter bit CLR_SEC_ON_SET = 1'b1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] digits,
    output logic [5:0]  cnt_en,
    output logic [5:0]  cnt_clr,
    output logic [1:0]  mode,
    output logic        day_wrap
);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_HR  = 2'b01;
    localparam logic [1:0] SET_MIN = 2'b10;

    logic [3:0] s0, s1, m0, m1, h0, h1;

    assign s0 = digits[3:0];
    assign s1 = digits[7:4];
    assign m0 = digits[11:8];
    assign m1 = digits[15:12];
    assign h0 = digits[19:16];
    assign h1 = digits[23:20];

    // Terminal detection uses >= so illegal values roll over instead of sticking.
    logic term_s0, term_s1, term_m0, term_m1, term_h0;
    logic hr_top;

    assign term_s0 = (s0 >= 4'd9);
    assign term_s1 = (s1 >= 4'd5);
    assign term_m0 = (m0 >= 4'd9);
    assign term_m1 = (m1 >= 4'd5);
    assign term_h0 = (h0 >= 4'd9);
    assign hr_top  = (h1 > 4'd2) || ((h1 == 4'd2) && (h0 >= 4'd3));

    logic [1:0] sec_en, sec_clr;
    logic [1:0] min_en, min_clr;
    logic [1:0] hr_en, hr_clr;
    logic       sec_carry, min_carry;

    assign sec_en    = {term_s0 & ~term_s1, ~term_s0};
    assign sec_clr   = {term_s0 & term_s1, term_s0};
    assign sec_carry = term_s0 & term_s1;

    assign min_en    = {term_m0 & ~term_m1, ~term_m0};
    assign min_clr   = {term_m0 & term_m1, term_m0};
    assign min_carry = term_m0 & term_m1;

    // Below 23, h0 terminal implies h1 is 0 or 1, so h1 can always step.
    assign hr_en  = {~hr_top & term_h0, ~hr_top & ~term_h0};
    assign hr_clr = {hr_top, hr_top | term_h0};

    logic run_tick, inc_hr, inc_min, sec_exit;
    logic adv_min, adv_hr;

    assign run_tick = (mode == RUN) && tick;
    assign inc_hr   = (mode == SET_HR) && btn_inc && !btn_mode;
    assign inc_min  = (mode == SET_MIN) && btn_inc && !btn_mode;
    assign sec_exit = CLR_SEC_ON_SET && (mode == SET_MIN) && btn_mode;
    assign adv_min  = (run_tick && sec_carry) || inc_min;
    assign adv_hr   = (run_tick && sec_carry && min_carry) || inc_hr;

    logic [5:0] en_nxt, clr_nxt;
    logic       wrap_nxt;
    logic [1:0] mode_nxt;

    always_comb begin
        en_nxt  = '0;
        clr_nxt = '0;
        if (run_tick) begin
            en_nxt[1:0]  = sec_en;
            clr_nxt[1:0] = sec_clr;
        end
        if (adv_min) begin
            en_nxt[3:2]  = min_en;
            clr_nxt[3:2] = min_clr;
        end
        if (adv_hr) begin
            en_nxt[5:4]  = hr_en;
            clr_nxt[5:4] = hr_clr;
        end
        if (sec_exit) begin
            en_nxt[1:0]  = 2'b00;
            clr_nxt[1:0] = 2'b11;
        end
    end

    assign wrap_nxt = run_tick && sec_carry && min_carry && hr_top;

    always_comb begin
        mode_nxt = mode;
        if (btn_mode) begin
            case (mode)
                RUN:     mode_nxt = SET_HR;
                SET_HR:  mode_nxt = SET_MIN;
                default: mode_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            mode     <= RUN;
            cnt_en   <= '0;
            cnt_clr  <= '0;
            day_wrap <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            cnt_en   <= en_nxt;
            cnt_clr  <= clr_nxt;
            day_wrap <= wrap_nxt;
        end
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Sequencing controller for the digital clock's six cascaded 4-bit digit counters (s0, s1, m0, m1, h0, h1). Each raw counter counts 0-15 and toggles only when its enable is high. This block reads the current digit values and issues per-digit count-enable and clear strobes so that the chain counts a 24-hour BCD time, 00:00:00-23:59:59. It also owns the time-set mode FSM driven by two pre-debounced, single-cycle button pulses.

Parameters:
CLR_SEC_ON_SET, 1, when 1, leaving SET_MIN clears both seconds digits.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
clear  input  1  synchronous, active-high reset.
tick  input  1  one-cycle 1 Hz pulse; never asserted in two consecutive cycles.
btn_mode  input  1  one-cycle pulse; advances the mode.
btn_inc  input  1  one-cycle pulse; increments the field selected in a set mode.
digits  input  24  current counter values {h1,h0,m1,m0,s1,s0}, 4 bits each, s0 in [3:0].
cnt_en  output  6  per-digit count enable (same bit order); registered one-cycle pulse.
cnt_clr  output  6  per-digit clear request, active-high; registered one-cycle pulse. Integration drives the counter's active-low clear from the inverse.
mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 is never driven.
day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (clear=1 at an edge): mode=RUN; cnt_en=0, cnt_clr=0, day_wrap=0. The counters are reset by their own clear.
- All outputs are registered. A qualifying input in cycle N produces strobes in cycle N+1, high for exactly one cycle, then 0.
- Per-digit terminal values: s0=9, s1=5, m0=9, m1=5, h0=9. Hours terminal is h1:h0=2:3. Any digit value >= its terminal counts as terminal (recovery from illegal values). Hours >= 24 are treated as 23.
- Ripple rule on an advance of digit k:
  - If digit k is not terminal, set cnt_en[k] only.
  - If digit k is terminal, set cnt_clr[k] and never cnt_en[k], then carry to digit k+1.
- Hours pair: if not at 23, h0 follows the rule above, with h0 terminal 9 carrying into h1. At 23, clear both h0 and h1.
- cnt_en[k] and cnt_clr[k] are never high together.
- RUN with tick: advance s0. Carries propagate s0 -> s1 -> m0 -> m1 -> h. day_wrap=1 only when all digits wrap at 23:59:59.
- Mode FSM on btn_mode: RUN -> SET_HR -> SET_MIN -> RUN.
  - On the SET_MIN -> RUN transition with CLR_SEC_ON_SET=1, assert cnt_clr[1:0] in the next cycle.
- SET_HR: tick is ignored; btn_inc advances the hours pair mod 24, with no carry out and no day_wrap.
- SET_MIN: tick is ignored; btn_inc advances m0/m1 mod 60, with no carry into hours.
- Simultaneous events:
  - btn_mode with btn_inc in the same cycle: btn_mode wins and btn_inc is dropped.
  - btn_mode with tick in RUN: the tick is processed (strobes issued) and the mode changes to SET_HR at the same edge.
- clear mid-sequence: pending strobes are cancelled; outputs are 0 in the next cycle.
- digits is sampled in the same cycle as the triggering pulse. Its next update occurs after the strobe edge, so the tick/button spacing rules guarantee fresh values.

Test Plan:
- Reset then RUN, digits=00:00:00, tick -> next cycle cnt_en=000001, cnt_clr=000000; following cycle all outputs 0.
- digits=00:00:59, tick -> cnt_clr=000011, cnt_en=000100, day_wrap=0.
- digits=23:59:59, tick -> cnt_clr=111111, cnt_en=000000, day_wrap=1. Also digits=19:59:59, tick -> cnt_clr=011111, cnt_en=100000.
- btn_mode x1, mode=01, digits=23:xx:xx, btn_inc -> cnt_clr=110000, no carry, day_wrap=0. A tick in SET_HR -> all strobes 0.
- mode=10, digits=12:59:30, btn_inc -> cnt_clr=001100, cnt_en=000000. Then btn_mode -> mode=00, cnt_clr=000011. btn_mode with btn_inc in the same cycle -> mode advances, no cnt_en/cnt_clr.
- Illegal digits s0=12, tick -> cnt_clr[0]=1, carry to s1. clear asserted in the cycle a tick arrives -> outputs stay 0, mode=00.
